axi4_slave_mem: RTL and testbench
=================================

# axi4_slave_mem

Parametrised AXI4 slave memory model that replaces the fixed 32-bit, sideband-heavy bus definition with a behavioural endpoint. It stores data in an internal byte-addressable array and answers full AXI4 write and read transactions on independent channels. It supports FIXED, INCR and WRAP bursts, narrow transfers, byte strobes and error responses. The block is the DUT-side target for the UVM master agent and scoreboard.

## Interface
Parameters:
- DATA_W, 32, data bus width in bits; legal values are 32, 64 and 128.
- ADDR_W, 32, address width in bits.
- ID_W, 5, transaction ID width in bits.
- DEPTH, 1024, memory depth in DATA_W-bit words.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_W/8.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all logic samples on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/8/3/2  write address payload.
- AWVALID  in  1; AWREADY  out  1  write address handshake.
- WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data beat.
- WVALID  in  1; WREADY  out  1  write data handshake.
- BID/BRESP  out  ID_W/2  write response.
- BVALID  out  1; BREADY  in  1  write response handshake.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/8/3/2  read address payload.
- ARVALID  in  1; ARREADY  out  1  read address handshake.
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data beat.
- RVALID  out  1; RREADY  in  1  read data handshake.

## Operation
- Write FSM has three states: W_IDLE, then W_DATA, then W_RESP, then back to W_IDLE.
  - AWREADY is 1 only in W_IDLE. An AW handshake captures ID, address, LEN, SIZE and BURST, and clears the beat counter and the error flag.
  - WREADY is 1 only in W_DATA. Each W handshake writes the bytes enabled by WSTRB on the byte lanes selected by the current address, then advances the address.
  - After beat AWLEN the FSM enters W_RESP and drives BVALID=1 with BID equal to the captured AWID. It returns to W_IDLE on BVALID && BREADY.
- Read FSM has two states: R_IDLE, then R_DATA, then back to R_IDLE.
  - ARREADY is 1 only in R_IDLE.
  - In R_DATA, RVALID=1, RID equals ARID and RDATA is the full word at the current address. RLAST=1 on beat ARLEN.
  - On each R handshake the address advances. The FSM returns to R_IDLE after the last beat.
- Address update uses step = 1<<SIZE:
  - FIXED (BURST=0): the address is unchanged.
  - INCR (BURST=1): addr + step.
  - WRAP (BURST=2): boundary = (LEN+1)*step; the next address is the wrap base plus ((addr+step) mod boundary).
- A burst receives SLVERR (2'b10) instead of OKAY (2'b00) in these cases:
  - BURST=3, or SIZE > log2(DATA_W/8): the whole burst is errored and no beats are written.
  - WRAP with LEN not equal to 1, 3, 7 or 15: the whole burst is errored and no beats are written.
  - A beat address falls outside BASE_ADDR .. BASE_ADDR+DEPTH*DATA_W/8-1: only that beat is suppressed (not written, or read data forced to 0), and the burst is errored.
  - WLAST does not match the beat count: the burst is errored.
- RRESP is reported per beat. BRESP is reported once per burst.
- The write and read FSMs run fully independently. If the same word is written and read on the same edge, the read beat shows the old data.
- Memory contents are not reset. Reset forces both FSMs to idle; beats already written stay in memory.

## Timing
- All outputs are registered. Every output is 0 while ARESETn=0. AWREADY and ARREADY rise on the first rising edge after reset is released.
- AW handshake at edge N: WREADY=1 from cycle N+1.
- W handshake of the last beat at edge M: BVALID=1 from M+1, WREADY=0 from M+1, AWREADY=1 from the edge after the B handshake.
- AR handshake at edge N: the first RVALID appears at N+1. With RREADY held high, all LEN+1 beats stream back to back and the final beat sits in cycle N+LEN+1.
- Once VALID is asserted, it and its payload hold stable until the handshake completes. RREADY=0 or BREADY=0 stalls the FSM indefinitely.
- Reset asserted mid-burst: outputs go to 0 asynchronously. No B response or R beat is produced for the aborted burst.
- Capacity is one outstanding burst per direction. A second AWVALID waits, with AWREADY=0, until B completes.

## Test plan
- INCR write of AWADDR=0x10, LEN=3, SIZE=2, data 0xA0..0xA3 with full strobes, then an INCR read of the same range: expect BRESP=0, RDATA 0xA0..0xA3, and RLAST=1 only on beat 3.
- WRAP read of ARADDR=0x38, LEN=3, SIZE=2 (DATA_W=32): expect beat addresses 0x38, 0x3C, 0x30, 0x34.
- Write 0x11223344 with WSTRB=4'b0101 over a preloaded 0xFFFFFFFF, then read it back: expect 0xFF22FF44.
- Write with AWBURST=3: expect BRESP=2'b10 and memory unchanged. Read with ARADDR one word past the top: expect RRESP=2'b10 and RDATA=0.
- Hold RREADY low for 5 cycles mid-burst: expect RDATA stable and no beats lost. Then assert ARESETn=0 mid-write: expect all outputs 0 immediately and AWREADY=1 one edge after release.

Source files
------------

// File: rtl/axi4_slave_mem_if.sv
// AXI4 channel bundle between a master (bench/agent) and axi4_slave_mem.
// Signal names follow the AXI4 naming so existing agents bind unchanged.
interface axi4_slave_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 5
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: byte-strobed word array behind independent write and read
// burst engines supporting FIXED/INCR/WRAP, narrow transfers and SLVERR.
module axi4_slave_mem #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       ID_W      = 5,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic             clk,
  input logic             ARESETn,
  axi4_slave_mem_if.slave bus
);
  localparam int unsigned     STRB_W    = DATA_W / 8;
  localparam int unsigned     LANE_W    = $clog2(STRB_W);
  localparam int unsigned     IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * STRB_W);
  localparam logic [1:0]      OKAY      = 2'b00;
  localparam logic [1:0]      SLVERR    = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> LANE_W;
    return off[IDX_W-1:0];
  endfunction

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'd3) || (32'(size) > LANE_W) || ((burst == 2'd2) && !wrap_len_ok);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] step, bound, sum, nxt;
    step  = ADDR_W'(1) << size;
    sum   = a + step;
    bound = (ADDR_W'(len) + ADDR_W'(1)) * step;
    case (burst)
      2'd0:    nxt = a;
      2'd2:    nxt = (a & ~(bound - ADDR_W'(1))) + (sum & (bound - ADDR_W'(1)));
      default: nxt = sum;
    endcase
    return nxt;
  endfunction

  // Lanes covered by a beat: from the address offset up to the end of its size-aligned slot.
  function automatic logic [STRB_W-1:0] lane_mask(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size);
    logic [LANE_W:0]     lo, hi, step;
    logic [STRB_W-1:0]   m;
    lo   = {1'b0, a[LANE_W-1:0]};
    step = (LANE_W+1)'(1) << size;
    hi   = (lo & ~(step - (LANE_W+1)'(1))) + step;
    for (int unsigned i = 0; i < STRB_W; i++)
      m[i] = ((LANE_W+1)'(i) >= lo) && ((LANE_W+1)'(i) < hi);
    return m;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write path ----------------
  w_state_t          w_state, w_next;
  logic              awready, wready, bvalid;
  logic [ID_W-1:0]   bid, w_id;
  logic [1:0]        bresp, w_burst;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic              w_bad, w_err;
  logic              aw_fire, w_fire, b_fire, w_last_beat, w_beat_err, mem_we;
  logic [STRB_W-1:0] mem_be;

  assign aw_fire     = bus.AWVALID && awready;
  assign w_fire      = bus.WVALID && wready;
  assign b_fire      = bvalid && bus.BREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = !in_range(w_addr) || (bus.WLAST != w_last_beat);
  assign mem_we      = w_fire && !w_bad && in_range(w_addr);
  assign mem_be      = bus.WSTRB & lane_mask(w_addr, w_size);

  always_ff @(posedge clk or negedge ARESETn)
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_next;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_fire) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ARESETn)
    if (!ARESETn) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
      if (aw_fire) begin
        w_id    <= bus.AWID;
        w_addr  <= bus.AWADDR;
        w_len   <= bus.AWLEN;
        w_size  <= bus.AWSIZE;
        w_burst <= bus.AWBURST;
        w_cnt   <= '0;
        w_bad   <= burst_bad(bus.AWLEN, bus.AWSIZE, bus.AWBURST);
        w_err   <= burst_bad(bus.AWLEN, bus.AWSIZE, bus.AWBURST);
      end
      if (w_fire) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err | w_beat_err;
        if (w_last_beat) begin
          bid   <= w_id;
          bresp <= (w_err || w_beat_err) ? SLVERR : OKAY;
        end
      end
    end

  // Storage is deliberately not reset so a reset never wipes committed beats.
  always_ff @(posedge clk)
    if (mem_we)
      for (int unsigned i = 0; i < STRB_W; i++)
        if (mem_be[i]) mem[word_idx(w_addr)][8*i +: 8] <= bus.WDATA[8*i +: 8];

  // ---------------- read path ----------------
  r_state_t          r_state, r_next;
  logic              arready, rvalid, rlast;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp, r_burst;
  logic [ADDR_W-1:0] r_addr, ld_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic              r_bad, ld_ok, ld_last;
  logic              ar_fire, r_fire, r_done;

  assign ar_fire = bus.ARVALID && arready;
  assign r_fire  = rvalid && bus.RREADY;
  assign r_done  = (r_cnt == r_len);

  always_ff @(posedge clk or negedge ARESETn)
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (r_fire && r_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Beat to present next: the first beat on AR, otherwise the following address.
  always_comb begin
    ld_addr = next_addr(r_addr, r_len, r_size, r_burst);
    ld_ok   = !r_bad && in_range(ld_addr);
    ld_last = ((r_cnt + 8'd1) == r_len);
    if (ar_fire) begin
      ld_addr = bus.ARADDR;
      ld_ok   = !burst_bad(bus.ARLEN, bus.ARSIZE, bus.ARBURST) && in_range(bus.ARADDR);
      ld_last = (bus.ARLEN == 8'd0);
    end
  end

  always_ff @(posedge clk or negedge ARESETn)
    if (!ARESETn) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
    end else begin
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_DATA);
      if (ar_fire) begin
        rid     <= bus.ARID;
        r_len   <= bus.ARLEN;
        r_size  <= bus.ARSIZE;
        r_burst <= bus.ARBURST;
        r_cnt   <= '0;
        r_bad   <= burst_bad(bus.ARLEN, bus.ARSIZE, bus.ARBURST);
      end else if (r_fire && !r_done) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (ar_fire || (r_fire && !r_done)) begin
        r_addr <= ld_addr;
        rdata  <= ld_ok ? mem[word_idx(ld_addr)] : '0;
        rresp  <= ld_ok ? OKAY : SLVERR;
        rlast  <= ld_last;
      end else if (r_fire) begin
        rlast <= 1'b0;
      end
    end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = bid;
  assign bus.BRESP   = bresp;
  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RID     = rid;
  assign bus.RDATA   = rdata;
  assign bus.RRESP   = rresp;
  assign bus.RLAST   = rlast;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: expected B/R responses are queued when
// a request is issued and popped by a monitor as the slave answers.
module tb_axi4_slave_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_slave_mem_if #(.DATA_W(32), .ADDR_W(32), .ID_W(5)) bus ();

  axi4_slave_mem #(
    .DATA_W(32), .ADDR_W(32), .ID_W(5), .DEPTH(1024), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .ARESETn(rst_n), .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [4:0]  id;
  } rexp_t;

  rexp_t      r_q[$];
  logic [6:0] b_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor samples on the falling edge; a VALID&&READY seen here completes on the next rising edge.
  rexp_t      re;
  logic [6:0] be;
  always @(negedge clk) begin
    if (rst_n && bus.RVALID && bus.RREADY) begin
      if (r_q.size() == 0) check("r_unexpected", 1, 0);
      else begin
        re = r_q.pop_front();
        check("rdata", bus.RDATA, re.data);
        check("rresp", bus.RRESP, re.resp);
        check("rlast", bus.RLAST, re.last);
        check("rid", bus.RID, re.id);
      end
    end
    if (rst_n && bus.BVALID && bus.BREADY) begin
      if (b_q.size() == 0) check("b_unexpected", 1, 0);
      else begin
        be = b_q.pop_front();
        check("bid", bus.BID, be[6:2]);
        check("bresp", bus.BRESP, be[1:0]);
      end
    end
  end

  task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic last,
                       input logic [4:0] id);
    rexp_t e;
    e.data = d; e.resp = resp; e.last = last; e.id = id;
    r_q.push_back(e);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [4:0] id,
                           input logic [1:0] exp_resp, input int unsigned last_beat);
    int n;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
    bus.AWBURST = burst; bus.AWVALID = 1'b1;
    b_q.push_back({id, exp_resp});
    n = 0;
    while (!bus.AWREADY && n < 100) begin tick(); n++; end
    if (n >= 100) check("aw_timeout", 0, 1);
    tick();
    bus.AWVALID = 1'b0;
    check("wready_after_aw", bus.WREADY, 1);
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      bus.WDATA = wdat[i]; bus.WSTRB = wstb[i]; bus.WLAST = (i == last_beat); bus.WVALID = 1'b1;
      n = 0;
      while (!bus.WREADY && n < 100) begin tick(); n++; end
      if (n >= 100) check("w_timeout", 0, 1);
      tick();
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    check("bvalid_after_w", bus.BVALID, 1);
    check("wready_after_w", bus.WREADY, 0);
    n = 0;
    while (b_q.size() != 0 && n < 100) begin tick(); n++; end
    if (n >= 100) check("b_timeout", 0, 1);
    check("awready_after_b", bus.AWREADY, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [4:0] id);
    int n;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
    bus.ARBURST = burst; bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 100) begin tick(); n++; end
    if (n >= 100) check("ar_timeout", 0, 1);
    tick();
    bus.ARVALID = 1'b0;
    check("rvalid_after_ar", bus.RVALID, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (r_q.size() != 0 && n < 200) begin tick(); n++; end
    if (n >= 200) check("r_timeout", 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, bus.AWREADY, 0);
    check({tag, "_wready"},  bus.WREADY,  0);
    check({tag, "_bvalid"},  bus.BVALID,  0);
    check({tag, "_arready"}, bus.ARREADY, 0);
    check({tag, "_rvalid"},  bus.RVALID,  0);
    check({tag, "_rdata"},   bus.RDATA,   0);
  endtask

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
    bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst_n = 1'b1;
    check("awready_before_edge", bus.AWREADY, 0);
    tick();
    check("awready_after_rst", bus.AWREADY, 1);
    check("arready_after_rst", bus.ARREADY, 1);

    // INCR write then read back
    for (int unsigned i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + i; wstb[i] = 4'hF; end
    axi_write(32'h10, 8'd3, 3'd2, 2'd1, 5'd3, 2'b00, 3);
    for (int unsigned i = 0; i < 4; i++) exp_r(32'hA0 + i, 2'b00, i == 3, 5'd7);
    axi_read(32'h10, 8'd3, 3'd2, 2'd1, 5'd7);
    drain();

    // FIXED read repeats the same word
    exp_r(32'hA0, 2'b00, 1'b0, 5'd2);
    exp_r(32'hA0, 2'b00, 1'b1, 5'd2);
    axi_read(32'h10, 8'd1, 3'd2, 2'd0, 5'd2);
    drain();

    // WRAP read: words hold their own address
    for (int unsigned i = 0; i < 4; i++) begin wdat[i] = 32'h30 + 4*i; wstb[i] = 4'hF; end
    axi_write(32'h30, 8'd3, 3'd2, 2'd1, 5'd4, 2'b00, 3);
    exp_r(32'h38, 2'b00, 1'b0, 5'd5);
    exp_r(32'h3C, 2'b00, 1'b0, 5'd5);
    exp_r(32'h30, 2'b00, 1'b0, 5'd5);
    exp_r(32'h34, 2'b00, 1'b1, 5'd5);
    axi_read(32'h38, 8'd3, 3'd2, 2'd2, 5'd5);
    drain();

    // Partial strobes over a preloaded word
    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
    axi_write(32'h100, 8'd0, 3'd2, 2'd1, 5'd1, 2'b00, 0);
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b0101;
    axi_write(32'h100, 8'd0, 3'd2, 2'd1, 5'd1, 2'b00, 0);

    // Illegal burst type and illegal WRAP length: errored, nothing written
    wdat[0] = 32'h0; wstb[0] = 4'hF;
    axi_write(32'h100, 8'd0, 3'd2, 2'd3, 5'd9, 2'b10, 0);
    for (int unsigned i = 0; i < 3; i++) begin wdat[i] = 32'h0; wstb[i] = 4'hF; end
    axi_write(32'h100, 8'd2, 3'd2, 2'd2, 5'd10, 2'b10, 2);
    exp_r(32'hFF22_FF44, 2'b00, 1'b1, 5'd11);
    axi_read(32'h100, 8'd0, 3'd2, 2'd1, 5'd11);
    drain();

    // Narrow byte write at an odd address lands on lane 1 only
    wdat[0] = 32'h0; wstb[0] = 4'hF;
    axi_write(32'h200, 8'd0, 3'd2, 2'd1, 5'd12, 2'b00, 0);
    wdat[0] = 32'hAABB_CCDD; wstb[0] = 4'hF;
    axi_write(32'h201, 8'd0, 3'd0, 2'd1, 5'd12, 2'b00, 0);
    exp_r(32'h0000_CC00, 2'b00, 1'b1, 5'd13);
    axi_read(32'h200, 8'd0, 3'd2, 2'd1, 5'd13);
    drain();

    // WLAST asserted on the wrong beat
    wdat[0] = 32'h1; wdat[1] = 32'h2; wstb[0] = 4'hF; wstb[1] = 4'hF;
    axi_write(32'h204, 8'd1, 3'd2, 2'd1, 5'd14, 2'b10, 0);

    // Top word in range, next beat out of range
    wdat[0] = 32'h5A5A_0FFC; wdat[1] = 32'hDEAD_BEEF; wstb[0] = 4'hF; wstb[1] = 4'hF;
    axi_write(32'hFFC, 8'd1, 3'd2, 2'd1, 5'd15, 2'b10, 1);
    exp_r(32'h5A5A_0FFC, 2'b00, 1'b0, 5'd16);
    exp_r(32'h0, 2'b10, 1'b1, 5'd16);
    axi_read(32'hFFC, 8'd1, 3'd2, 2'd1, 5'd16);
    drain();
    exp_r(32'h0, 2'b10, 1'b1, 5'd17);
    axi_read(32'h1000, 8'd0, 3'd2, 2'd1, 5'd17);
    drain();

    // RREADY held low mid-burst
    bus.RREADY = 1'b0;
    for (int unsigned i = 0; i < 4; i++) exp_r(32'hA0 + i, 2'b00, i == 3, 5'd18);
    axi_read(32'h10, 8'd3, 3'd2, 2'd1, 5'd18);
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      check("stall_rdata", bus.RDATA, 32'hA1);
      check("stall_rvalid", bus.RVALID, 1);
      tick();
    end
    bus.RREADY = 1'b1;
    drain();

    // Reset during a write burst after two beats
    bus.AWID = 5'd20; bus.AWADDR = 32'h300; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd2;
    bus.AWBURST = 2'd1; bus.AWVALID = 1'b1;
    while (!bus.AWREADY) tick();
    tick();
    bus.AWVALID = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      bus.WDATA = 32'hB0 + i; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
      check("abort_wready", bus.WREADY, 1);
      tick();
    end
    bus.WVALID = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_awready_before_edge", bus.AWREADY, 0);
    tick();
    check("abort_awready_after_edge", bus.AWREADY, 1);
    exp_r(32'hB0, 2'b00, 1'b0, 5'd21);
    exp_r(32'hB1, 2'b00, 1'b1, 5'd21);
    axi_read(32'h300, 8'd1, 3'd2, 2'd1, 5'd21);
    drain();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
